// File: rtl/adder32_registered.sv
`default_nettype none
// ============================================================================
// Module   : adder32_registered
// Brief    : Registered unsigned adder with a selectable carry network.
//            Supports two-level carry-lookahead or a ripple chain of full adders.
// Revision : 1.0  initial release
// ============================================================================
module adder32_registered #(
  parameter int WIDTH   = 32,
  parameter bit USE_CLA = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);

  localparam int NUM_GROUPS = WIDTH / 4;

  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] sum_d, sum_q;
  logic             cout_d, cout_q;

  generate
    if (USE_CLA) begin : g_cla
      logic [WIDTH-1:0]      g, p;
      logic [NUM_GROUPS-1:0] grp_g, grp_p;
      logic [NUM_GROUPS:0]   grp_c;
      logic                  term, acc;

      assign g = i_a & i_b;
      assign p = i_a ^ i_b;

      for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_group
        logic [3:0] gl, pl, cl;
        assign gl = g[4*k +: 4];
        assign pl = p[4*k +: 4];
        assign cl[0] = grp_c[k];
        assign cl[1] = gl[0] | (pl[0] & grp_c[k]);
        assign cl[2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & grp_c[k]);
        assign cl[3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                     | (pl[2] & pl[1] & pl[0] & grp_c[k]);
        assign grp_g[k] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                        | (pl[3] & pl[2] & pl[1] & gl[0]);
        assign grp_p[k] = &pl;
        assign add_sum[4*k +: 4] = pl ^ cl;
      end

      // Second-level lookahead: every group carry is a flat sum of products
      // over the lower groups' G/P, so no carry ripples from group to group.
      always_comb begin
        grp_c = '0;
        term  = 1'b0;
        acc   = 1'b0;
        for (int k = 1; k <= NUM_GROUPS; k++) begin
          acc = 1'b0;
          for (int m = 0; m < k; m++) begin
            acc = acc & grp_p[m];
          end
          for (int j = 0; j < k; j++) begin
            term = grp_g[j];
            for (int m = j + 1; m < k; m++) begin
              term = term & grp_p[m];
            end
            acc = acc | term;
          end
          grp_c[k] = acc;
        end
      end

      assign add_cout = grp_c[NUM_GROUPS];
    end else begin : g_ripple
      logic [WIDTH:0] c;
      assign c[0] = 1'b0;
      for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign add_sum[i] = i_a[i] ^ i_b[i] ^ c[i];
        assign c[i+1]     = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
      end
      assign add_cout = c[WIDTH];
    end
  endgenerate

  always_comb begin
    sum_d  = add_sum;
    cout_d = add_cout;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign o_sum  = sum_q;
  assign o_cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_adder32_registered.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder32_registered
// Brief    : Self-checking bench running CLA and ripple builds side by side.
// Revision : 1.0  initial release
// ============================================================================
module tb_adder32_registered;

  logic        clk;
  logic        rst_n;
  logic [31:0] a, b;
  logic [31:0] sum_cla, sum_rip;
  logic        cout_cla, cout_rip;

  int n_checks;
  int n_errors;

  adder32_registered #(.WIDTH(32), .USE_CLA(1'b1)) dut_cla (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_a    (a),
    .i_b    (b),
    .o_sum  (sum_cla),
    .o_cout (cout_cla)
  );

  adder32_registered #(.WIDTH(32), .USE_CLA(1'b0)) dut_rip (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_a    (a),
    .i_b    (b),
    .o_sum  (sum_rip),
    .o_cout (cout_rip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_both(input string tag, input logic [32:0] exp);
    check({tag, "_cla"}, {cout_cla, sum_cla}, exp);
    check({tag, "_rip"}, {cout_rip, sum_rip}, exp);
  endtask

  // Present operands, take one edge, then check the registered result.
  task automatic run_vec(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [32:0] exp);
    a = va;
    b = vb;
    @(posedge clk);
    #1;
    check_both(tag, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b1;
    a = 32'h1234_5678;
    b = 32'h1111_1111;
    #1 rst_n = 1'b0;
    #1 check_both("reset_async", 33'h0_0000_0000);
    @(posedge clk);
    #1 check_both("reset_held", 33'h0_0000_0000);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check_both("reset_release", 33'h0_2345_6789);

    for (int i = 0; i < 100; i++) begin
      ra = 32'($urandom_range(255));
      rb = 32'($urandom_range(255));
      run_vec("small", ra, rb, {1'b0, ra} + {1'b0, rb});
    end
    run_vec("small_200_100", 32'd200, 32'd100, 33'd300);

    run_vec("full_carry", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
    run_vec("msb_carry", 32'h7FFF_FFFF, 32'h0000_0001, 33'h0_8000_0000);
    run_vec("group0", 32'h0000_000F, 32'h0000_0001, 33'h0_0000_0010);
    run_vec("group7", 32'h0FFF_FFFF, 32'h0000_0001, 33'h0_1000_0000);
    run_vec("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
    run_vec("alt_bits", 32'hAAAA_AAAA, 32'h5555_5555, 33'h0_FFFF_FFFF);
    run_vec("zero", 32'h0, 32'h0, 33'h0_0000_0000);

    run_vec("b2b_0", 32'd1, 32'd2, 33'd3);
    run_vec("b2b_1", 32'd3, 32'd4, 33'd7);
    run_vec("b2b_2", 32'hFFFF_FFFF, 32'd2, 33'h1_0000_0001);

    // Reset asserted between edges discards the result; held operands load after release.
    a = 32'h8000_0000;
    b = 32'h8000_0001;
    #2 rst_n = 1'b0;
    #1 check_both("midreset_async", 33'h0_0000_0000);
    @(posedge clk);
    #1 check_both("midreset_held", 33'h0_0000_0000);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 check_both("midreset_release", 33'h1_0000_0001);

    for (int i = 0; i < 10000; i++) begin
      ra = $urandom;
      rb = $urandom;
      run_vec("random", ra, rb, {1'b0, ra} + {1'b0, rb});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder32_registered.md
Name: adder32_registered

Overview:
- Registered WIDTH-bit unsigned binary adder.
- Computes sum and carry-out of two operands and presents them one clock after capture.
- Internal carry structure is selectable: carry-lookahead (default) or carry-ripple. Both must be bit-identical at the outputs.
- Used as the integer add datapath element wherever a 32-bit registered sum is needed.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of 4.
- USE_CLA, 1, 1 = carry-lookahead carry network, 0 = carry-ripple chain of full adders.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_a  input  WIDTH  operand A, unsigned.
- i_b  input  WIDTH  operand B, unsigned.
- o_sum  output  WIDTH  registered (i_a + i_b) mod 2^WIDTH.
- o_cout  output  1  registered carry-out of bit WIDTH-1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (i_clk, i_rst_n).
- Reset
  - While i_rst_n = 0, o_sum = 0 and o_cout = 0, immediately and without waiting for a clock edge.
  - The first rising edge with i_rst_n = 1 captures a new result.
- Latency
  - Exactly 1 cycle: at each rising edge, o_sum/o_cout load the result for the i_a/i_b present before that edge.
  - New operands are accepted every cycle; there is no handshake and no stall.
- Arithmetic
  - Unsigned; the carry-in to bit 0 is fixed at 0.
  - {o_cout, o_sum} = i_a + i_b as a (WIDTH+1)-bit result.
  - Overflow wraps: o_sum is the low WIDTH bits and o_cout = 1.
- Carry-lookahead structure (USE_CLA = 1)
  - Per-bit generate g = a & b and propagate p = a ^ b.
  - 4-bit lookahead blocks produce internal carries plus group G/P.
  - A second-level lookahead unit over the WIDTH/4 groups produces each group carry-in, with no ripple between groups.
  - sum bit = p ^ carry-in.
- Ripple structure (USE_CLA = 0)
  - WIDTH chained full adders.
  - sum = a ^ b ^ c; cout = (a & b) | (c & (a ^ b)).
- Equivalence: both architectures give identical o_sum/o_cout for all inputs.
- The combinational path from inputs to register is pure logic; there are no latches.
- Reset mid-operation: an in-flight result is discarded and outputs go to 0. Operands held across reset release are captured at the first edge after release.
- X-handling is not required; inputs are assumed driven.

Test Plan:
- Reset: hold i_rst_n = 0 with i_a = 0x12345678, i_b = 0x11111111 -> o_sum = 0x00000000 and o_cout = 0, with no clock edge needed. Release, then one edge -> o_sum = 0x23456789, o_cout = 0.
- Random small operands: 100 vectors with i_a, i_b in 0..255 (e.g. 200 + 100) -> o_sum = 300 one cycle later. Bench counts PASS/FAIL per vector and requires FAIL = 0.
- Full carry propagation:
  - 0xFFFFFFFF + 0x00000001 -> o_sum = 0x00000000, o_cout = 1.
  - 0x7FFFFFFF + 0x00000001 -> o_sum = 0x80000000, o_cout = 0.
- Group boundaries: 0x0000000F + 0x00000001 -> 0x00000010. 0x0FFFFFFF + 0x00000001 -> 0x10000000. 0xFFFFFFFF + 0xFFFFFFFF -> o_sum = 0xFFFFFFFE, o_cout = 1.
- Back-to-back throughput: apply (1,2), (3,4), (0xFFFFFFFF,2) on consecutive edges -> o_sum = 3, 7, 1 on the following consecutive cycles, with o_cout = 0, 0, 1.
- Architecture equivalence: instantiate USE_CLA = 1 and USE_CLA = 0 side by side on the same 10000 random full-range vectors -> o_sum and o_cout match the reference model and each other on every cycle.
